// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider; divisor writes are double-buffered and applied at period wrap or sync.
// Define CLKDIV_READBACK_EN to build the n_clks readback mux; otherwise n_clks is tied to zero.
module clock_divider_multi #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned RESET_DIV = 4,
  parameter int unsigned SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                in_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sync,
  input  logic                div_wr,
  input  logic [SEL_W-1:0]    div_sel,
  input  logic [WIDTH-1:0]    div_data,
  output logic [CHANNELS-1:0] pend_busy,
  output logic [WIDTH-1:0]    n_clks,
  output logic [CHANNELS-1:0] out_clk,
  output logic [CHANNELS-1:0] tick
);

`ifdef CLKDIV_READBACK_EN
  logic [WIDTH-1:0] cnt_all [CHANNELS];
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] p_q;
    logic             pend_q;
    logic             out_q;
    logic             tick_q;
    logic             wr_hit;
    logic             wrap;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH:0]   half;
    logic [WIDTH-1:0] d_sync;

    assign wr_hit  = div_wr && (div_sel == SEL_W'(i));
    assign wrap    = (cnt_q == d_q - WIDTH'(1));
    assign cnt_inc = cnt_q + WIDTH'(1);
    // Extra bit keeps D = all-ones from overflowing the high-time computation.
    assign half    = ({1'b0, d_q} + (WIDTH+1)'(1)) >> 1;
    // A write coinciding with sync takes effect immediately, ahead of any older pending value.
    assign d_sync  = wr_hit ? div_data : (pend_q ? p_q : d_q);

    always_ff @(posedge in_clk or negedge reset) begin
      if (!reset) begin
        cnt_q  <= '0;
        d_q    <= WIDTH'(RESET_DIV);
        p_q    <= '0;
        pend_q <= 1'b0;
        out_q  <= (RESET_DIV != 0);
        tick_q <= 1'b0;
      end else begin
        if (sync) begin
          cnt_q  <= '0;
          d_q    <= d_sync;
          pend_q <= 1'b0;
          out_q  <= (d_sync != '0);
          tick_q <= (d_sync != '0);
        end else if (d_q == '0) begin
          cnt_q <= '0;
          if (pend_q) begin
            d_q    <= p_q;
            pend_q <= 1'b0;
            out_q  <= (p_q != '0);
            tick_q <= enable && (p_q != '0);
          end else begin
            out_q  <= 1'b0;
            tick_q <= 1'b0;
          end
        end else if (!enable) begin
          tick_q <= 1'b0;
        end else if (wrap) begin
          cnt_q <= '0;
          if (pend_q) begin
            d_q    <= p_q;
            pend_q <= 1'b0;
            out_q  <= (p_q != '0);
            tick_q <= (p_q != '0);
          end else begin
            out_q  <= 1'b1;
            tick_q <= 1'b1;
          end
        end else begin
          cnt_q  <= cnt_inc;
          out_q  <= ({1'b0, cnt_inc} < half);
          tick_q <= 1'b0;
        end
        // A write landing on an apply edge stays pending for the following period.
        if (wr_hit && !sync) begin
          p_q    <= div_data;
          pend_q <= 1'b1;
        end
      end
    end

    assign pend_busy[i] = pend_q;
    assign out_clk[i]   = out_q;
    assign tick[i]      = tick_q;
`ifdef CLKDIV_READBACK_EN
    assign cnt_all[i]   = cnt_q;
`endif
  end

`ifdef CLKDIV_READBACK_EN
  always_comb begin
    n_clks = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (div_sel == SEL_W'(i)) n_clks = cnt_all[i];
    end
  end
`else
  assign n_clks = '0;
`endif

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: cycle-by-cycle comparison against a rule-level model plus directed literal checks.
module tb_clock_divider_multi;
  localparam int CH = 4;
  localparam int W  = 32;
  localparam int RD = 4;

  logic          in_clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          sync = 1'b0;
  logic          div_wr = 1'b0;
  logic [1:0]    div_sel = '0;
  logic [W-1:0]  div_data = '0;
  logic [CH-1:0] pend_busy;
  logic [W-1:0]  n_clks;
  logic [CH-1:0] out_clk;
  logic [CH-1:0] tick;

  int total = 0;
  int bad = 0;

  clock_divider_multi #(.WIDTH(W), .CHANNELS(CH), .RESET_DIV(RD)) dut (
    .in_clk(in_clk), .reset(reset), .enable(enable), .sync(sync),
    .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
    .pend_busy(pend_busy), .n_clks(n_clks), .out_clk(out_clk), .tick(tick)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: count position, active/pending divisor, pending flag, tick.
  int unsigned m_cnt [CH];
  int unsigned m_d   [CH];
  int unsigned m_p   [CH];
  bit          m_pend[CH];
  bit          m_tick[CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_d[c] = RD; m_p[c] = 0; m_pend[c] = 0; m_tick[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit hit;
      hit = div_wr && (int'(div_sel) == c);
      if (sync) begin
        if (hit) m_d[c] = div_data;
        else if (m_pend[c]) m_d[c] = m_p[c];
        if (hit) m_p[c] = div_data;
        m_pend[c] = 0;
        m_cnt[c]  = 0;
        m_tick[c] = (m_d[c] != 0);
      end else begin
        if (m_d[c] == 0) begin
          m_cnt[c] = 0;
          m_tick[c] = 0;
          if (m_pend[c]) begin
            m_d[c] = m_p[c];
            m_pend[c] = 0;
            m_tick[c] = enable && (m_d[c] != 0);
          end
        end else if (enable) begin
          if (m_cnt[c] + 1 == m_d[c]) begin
            m_cnt[c] = 0;
            if (m_pend[c]) begin
              m_d[c] = m_p[c];
              m_pend[c] = 0;
            end
            m_tick[c] = (m_d[c] != 0);
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
            m_tick[c] = 0;
          end
        end else begin
          m_tick[c] = 0;
        end
        if (hit) begin
          m_p[c] = div_data;
          m_pend[c] = 1;
        end
      end
    end
  endtask

  initial model_reset();

  always @(posedge in_clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // out_clk must equal (cnt < ceil(D/2)) at all times.
  always @(negedge in_clk) begin
    logic [CH-1:0] eo, et, ep;
    longint en;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        eo[c] = longint'(m_cnt[c]) < (longint'(m_d[c]) + 1) / 2;
        et[c] = m_tick[c];
        ep[c] = m_pend[c];
      end
`ifdef CLKDIV_READBACK_EN
      en = (int'(div_sel) < CH) ? longint'(m_cnt[div_sel]) : 0;
`else
      en = 0;
`endif
      chk("model out_clk", longint'(out_clk), longint'(eo));
      chk("model tick", longint'(tick), longint'(et));
      chk("model pend_busy", longint'(pend_busy), longint'(ep));
      chk("model n_clks", longint'(n_clks), en);
    end
  end

  // Tasks start and end on a falling edge; inputs change 1 time unit after it.
  task automatic write_div(input int sel, input int unsigned data);
    #1 div_wr = 1'b1; div_sel = 2'(sel); div_data = data;
    @(posedge in_clk);
    #1 div_wr = 1'b0;
    @(negedge in_clk);
  endtask

  task automatic pulse_sync();
    #1 sync = 1'b1;
    @(posedge in_clk);
    #1 sync = 1'b0;
    @(negedge in_clk);
  endtask

  initial begin
    logic [7:0]  s8o, s8t;
    logic [9:0]  s10o, s10t;
    logic [15:0] tv;
    logic [6:0]  t1v, t3v;
    logic [CH-1:0] held;
    int pc, cnt_ok;
    bit found;

    repeat (3) @(negedge in_clk);
    chk("reset out_clk", longint'(out_clk), 4'hF);
    chk("reset tick", longint'(tick), 0);
    chk("reset pend_busy", longint'(pend_busy), 0);
    chk("reset n_clks", longint'(n_clks), 0);

    #1 reset = 1'b1; enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge in_clk);
      s8o[k] = out_clk[0];
      s8t[k] = tick[0];
    end
    chk("div4 out_clk[0] pattern", longint'(s8o), 8'h99);
    chk("div4 tick[0] pattern", longint'(s8t), 8'h88);
    chk("div4 pend_busy idle", longint'(pend_busy), 0);

    write_div(1, 5);
    chk("pend_busy[1] after write", longint'(pend_busy[1]), 1);
    pulse_sync();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge in_clk);
      s10o[k] = out_clk[1];
      s10t[k] = tick[1];
`ifdef CLKDIV_READBACK_EN
      if (k == 4) chk("n_clks ch1 at count 4", longint'(n_clks), 4);
`endif
    end
    chk("div5 out_clk[1] pattern", longint'(s10o), 10'h0E7);
    chk("div5 tick[1] pattern", longint'(s10t), 10'h021);

    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge in_clk);
      if (tick[0]) found = 1;
    end
    chk("wait tick[0] found", longint'(found), 1);
    write_div(0, 7);
    pc = 0; tv = '0;
    for (int s = 1; s <= 12; s++) begin
      if (s > 1) @(negedge in_clk);
      pc += int'(pend_busy[0]);
      tv[s] = tick[0];
    end
    chk("pend_busy[0] high cycles", longint'(pc), 3);
    chk("div7 tick[0] positions", longint'(tv), 16'h0810);

    write_div(2, 0);
    repeat (8) @(negedge in_clk);
    chk("stopped out_clk[2]", longint'(out_clk[2]), 0);
    chk("stopped tick[2]", longint'(tick[2]), 0);
    write_div(2, 1);
    chk("pend_busy[2] while stopped", longint'(pend_busy[2]), 1);
    cnt_ok = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge in_clk);
      if (out_clk[2] && tick[2]) cnt_ok++;
    end
    chk("div1 held high cycles", longint'(cnt_ok), 6);

    write_div(3, 3);
    write_div(1, 6);
    pulse_sync();
    chk("sync tick ch1 ch3", longint'({tick[3], tick[1]}), 2'b11);
`ifdef CLKDIV_READBACK_EN
    chk("sync n_clks ch1", longint'(n_clks), 0);
`endif
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge in_clk);
      t1v[k] = tick[1];
      t3v[k] = tick[3];
    end
    chk("div6 tick[1] positions", longint'(t1v), 7'h41);
    chk("div3 tick[3] positions", longint'(t3v), 7'h49);

    repeat (2) @(negedge in_clk);
    held = out_clk;
    #1 enable = 1'b0;
    cnt_ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge in_clk);
      if (out_clk == held && tick == '0) cnt_ok++;
    end
    chk("freeze cycles", longint'(cnt_ok), 10);
`ifdef CLKDIV_READBACK_EN
    chk("freeze n_clks ch1", longint'(n_clks), 2);
`endif
    #1 enable = 1'b1;
    repeat (3) @(negedge in_clk);
`ifdef CLKDIV_READBACK_EN
    chk("resume n_clks ch1", longint'(n_clks), 5);
`endif

    write_div(0, 9);
    chk("pend_busy[0] before reset", longint'(pend_busy[0]), 1);
    #3 reset = 1'b0;
    #1;
    chk("async reset out_clk", longint'(out_clk), 4'hF);
    chk("async reset tick", longint'(tick), 0);
    chk("async reset pend_busy", longint'(pend_busy), 0);
    chk("async reset n_clks", longint'(n_clks), 0);
    @(negedge in_clk);
    #1 reset = 1'b1;
    repeat (8) @(negedge in_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
